// File: rtl/entropy_ctrl_pkg.sv
// Shared types and constants for the entropy core sequencer (entropy_ctrl).
package entropy_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CFG0,
        CFG1,
        WAIT,
        RD_P,
        RD_N,
        MIX,
        OUT
    } state_e;

    localparam logic [7:0] ADDR_RNG1   = 8'h00;
    localparam logic [7:0] ADDR_RNG2   = 8'h01;
    localparam logic [7:0] ADDR_CFG_RD = 8'h10;
    localparam logic [7:0] ADDR_P      = 8'h11;
    localparam logic [7:0] ADDR_N      = 8'h12;

    localparam logic [7:0] RNG1_RST = 8'h55;
    localparam logic [7:0] RNG2_RST = 8'haa;

endpackage

// File: rtl/entropy_ctrl_health.sv
// Repetition health test: counts consecutive identical samples, pulses fail at REP_LIMIT.
module entropy_health #(
    parameter int unsigned REP_LIMIT = 4
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic [15:0] sample,
    input  logic        strobe,
    input  logic        clear,
    output logic        fail
);

    localparam int unsigned RW  = $clog2(REP_LIMIT + 1);
    localparam logic [RW-1:0] LIM = RW'(REP_LIMIT);

    logic [15:0]   prev_q;
    logic [RW-1:0] rep_q;
    logic [RW-1:0] rep_d;

    // rep_q == 0 means no previous sample, so the first one always starts a new run
    always_comb begin
        rep_d = rep_q;
        if (strobe) begin
            if ((rep_q != '0) && (sample == prev_q)) begin
                rep_d = (rep_q == LIM) ? LIM : rep_q + 1'b1;
            end else begin
                rep_d = RW'(1);
            end
        end
    end

    assign fail = strobe && !clear && (rep_d >= LIM);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            prev_q <= '0;
            rep_q  <= '0;
        end else if (clear) begin
            rep_q  <= '0;
        end else if (strobe) begin
            rep_q  <= rep_d;
            prev_q <= sample;
        end
    end

endmodule

// File: rtl/entropy_ctrl.sv
// Entropy core sequencer: configures the core, reads/whitens p^n samples, health-tests, packs 32-bit words.
// Optional ENTROPY_CTRL_STATS_EN adds words_cnt/fail_cnt saturating counters.
module entropy_ctrl
    import entropy_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV = 16,
    parameter int unsigned REP_LIMIT  = 4
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        enable,
    input  logic        cfg_stb,
    input  logic [7:0]  rng1_cfg,
    input  logic [7:0]  rng2_cfg,
    output logic        ent_cs,
    output logic        ent_we,
    output logic [7:0]  ent_addr,
    output logic [15:0] ent_dwrite,
    input  logic [15:0] ent_dread,
    output logic [31:0] data,
    output logic        data_valid,
    input  logic        data_ready,
    output logic        health_err,
    output logic        busy
`ifdef ENTROPY_CTRL_STATS_EN
    ,
    output logic [15:0] words_cnt,
    output logic [15:0] fail_cnt
`endif
);

    localparam int unsigned CW = $clog2(SAMPLE_DIV + 1);
    localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    cfg1_q, cfg2_q;
    logic          pend_q;
    logic          samp_q;
    logic [15:0]   p_q, n_q;
    logic [31:0]   data_q;
    logic          herr_q;
    logic [15:0]   mix_s;
    logic          hfail;

    assign mix_s = p_q ^ n_q;

    entropy_health #(.REP_LIMIT(REP_LIMIT)) u_health (
        .clk    (clk),
        .nreset (nreset),
        .sample (mix_s),
        .strobe (state_q == MIX),
        .clear  (cfg_stb),
        .fail   (hfail)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (enable) state_d = pend_q ? CFG0 : WAIT;
            CFG0: state_d = enable ? CFG1 : IDLE;
            CFG1: state_d = enable ? WAIT : IDLE;
            WAIT: begin
                if (!enable) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == LAST) begin
                    state_d = pend_q ? CFG0 : RD_P;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            RD_P: state_d = enable ? RD_N : IDLE;
            RD_N: state_d = enable ? MIX : IDLE;
            MIX: begin
                if (!enable)              state_d = IDLE;
                else if (samp_q && !hfail) state_d = OUT;
                else                      state_d = WAIT;
            end
            OUT: if (data_ready) state_d = !enable ? IDLE : (pend_q ? CFG0 : WAIT);
            default: state_d = IDLE;
        endcase
    end

    // Bus outputs depend on registered state and cfg only
    always_comb begin
        ent_cs     = 1'b0;
        ent_we     = 1'b0;
        ent_addr   = '0;
        ent_dwrite = '0;
        case (state_q)
            CFG0: begin ent_cs = 1'b1; ent_we = 1'b1; ent_addr = ADDR_RNG1; ent_dwrite = {cfg1_q, 8'h00}; end
            CFG1: begin ent_cs = 1'b1; ent_we = 1'b1; ent_addr = ADDR_RNG2; ent_dwrite = {8'h00, cfg2_q}; end
            RD_P: begin ent_cs = 1'b1; ent_addr = ADDR_P; end
            RD_N: begin ent_cs = 1'b1; ent_addr = ADDR_N; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cfg1_q  <= RNG1_RST;
            cfg2_q  <= RNG2_RST;
            pend_q  <= 1'b1;
            samp_q  <= 1'b0;
            p_q     <= '0;
            n_q     <= '0;
            data_q  <= '0;
            herr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (cfg_stb) begin
                cfg1_q <= rng1_cfg;
                cfg2_q <= rng2_cfg;
            end
            if (cfg_stb)              pend_q <= 1'b1;
            else if (state_q == CFG1) pend_q <= 1'b0;
            if (cfg_stb)    herr_q <= 1'b0;
            else if (hfail) herr_q <= 1'b1;
            if (state_q == RD_P) p_q <= ent_dread;
            if (state_q == RD_N) n_q <= ent_dread;
            if (state_q == MIX && !hfail) begin
                if (samp_q) data_q[31:16] <= mix_s;
                else        data_q[15:0]  <= mix_s;
            end
            // any return to IDLE drops a half-built word
            if (state_d == IDLE)     samp_q <= 1'b0;
            else if (state_q == MIX) samp_q <= hfail ? 1'b0 : ~samp_q;
        end
    end

    assign data       = data_q;
    assign data_valid = (state_q == OUT);
    assign health_err = herr_q;
    assign busy       = (state_q != IDLE);

`ifdef ENTROPY_CTRL_STATS_EN
    logic [15:0] words_q, fails_q;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            words_q <= '0;
            fails_q <= '0;
        end else if (cfg_stb) begin
            words_q <= '0;
            fails_q <= '0;
        end else begin
            if (data_valid && data_ready && (words_q != '1)) words_q <= words_q + 1'b1;
            if (hfail && (fails_q != '1))                    fails_q <= fails_q + 1'b1;
        end
    end

    assign words_cnt = words_q;
    assign fail_cnt  = fails_q;
`endif

endmodule

// File: tb/tb_entropy_ctrl.sv
// Scoreboard bench for entropy_ctrl: bus-level core model, sample-level reference model, decoupled word monitor.
module tb_entropy_ctrl;

    localparam int unsigned SAMPLE_DIV = 16;
    localparam int unsigned REP_LIMIT  = 4;

    logic        clk = 1'b0;
    logic        nreset, enable, cfg_stb, data_ready;
    logic [7:0]  rng1_cfg, rng2_cfg;
    logic        ent_cs, ent_we;
    logic [7:0]  ent_addr;
    logic [15:0] ent_dwrite, ent_dread;
    logic [31:0] data;
    logic        data_valid, health_err, busy;
`ifdef ENTROPY_CTRL_STATS_EN
    logic [15:0] words_cnt, fail_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    entropy_ctrl #(.SAMPLE_DIV(SAMPLE_DIV), .REP_LIMIT(REP_LIMIT)) dut (
        .clk        (clk),
        .nreset     (nreset),
        .enable     (enable),
        .cfg_stb    (cfg_stb),
        .rng1_cfg   (rng1_cfg),
        .rng2_cfg   (rng2_cfg),
        .ent_cs     (ent_cs),
        .ent_we     (ent_we),
        .ent_addr   (ent_addr),
        .ent_dwrite (ent_dwrite),
        .ent_dread  (ent_dread),
        .data       (data),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .health_err (health_err),
        .busy       (busy)
`ifdef ENTROPY_CTRL_STATS_EN
        ,
        .words_cnt  (words_cnt),
        .fail_cnt   (fail_cnt)
`endif
    );

    // Core register file model: p/n banks answer combinationally
    logic [15:0] core_p, core_n, nxt_p, nxt_n;
    logic [31:0] pairs[$];
    bit          const_mode = 1'b0;
    bit          rnd_ready  = 1'b0;

    assign ent_dread = (ent_cs && !ent_we && ent_addr == 8'h11) ? core_p :
                       (ent_cs && !ent_we && ent_addr == 8'h12) ? core_n : 16'h0000;

    function automatic void next_pair();
        logic [31:0] pr;
        if (pairs.size() > 0) begin
            pr    = pairs.pop_front();
            nxt_p = pr[31:16];
            nxt_n = pr[15:0];
        end else if (const_mode) begin
            nxt_p = 16'h0f0f;
            nxt_n = 16'h0000;
        end else if ($urandom_range(0, 2) != 0) begin
            nxt_p = 16'($urandom);
            nxt_n = 16'($urandom);
        end
    endfunction

    // Reference model: whitened samples, repetition runs, word pairing
    logic [15:0] m_prev;
    int unsigned m_rep;
    bit          m_half_v, m_err;
    logic [15:0] m_half;
    int          m_words, m_trips;
    logic [31:0] exp_words[$];
    logic [23:0] exp_wr[$];

    bit          pend_s, chk_next, prev_valid;
    logic [15:0] pend_val, obs_p;
    logic [31:0] prev_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        total++;
        bad++;
        $display("FAIL %s: got %h, nothing was expected", name, act);
    endtask

    function automatic void model_sample(input logic [15:0] s);
        if (m_rep > 0 && s == m_prev) m_rep = (m_rep < REP_LIMIT) ? m_rep + 1 : m_rep;
        else                          m_rep = 1;
        m_prev = s;
        if (m_rep >= REP_LIMIT) begin
            m_err    = 1'b1;
            m_half_v = 1'b0;
            m_trips++;
        end else if (!m_half_v) begin
            m_half   = s;
            m_half_v = 1'b1;
        end else begin
            exp_words.push_back({s, m_half});
            m_half_v = 1'b0;
        end
    endfunction

    function automatic void model_cfg(input logic [7:0] r1, input logic [7:0] r2);
        m_rep   = 0;
        m_err   = 1'b0;
        m_words = 0;
        m_trips = 0;
        exp_wr.push_back({8'h00, r1, 8'h00});
        exp_wr.push_back({8'h01, 8'h00, r2});
    endfunction

    function automatic void model_reset();
        m_rep      = 0;
        m_half_v   = 1'b0;
        m_err      = 1'b0;
        m_words    = 0;
        m_trips    = 0;
        pend_s     = 1'b0;
        chk_next   = 1'b0;
        prev_valid = 1'b0;
        exp_words.delete();
        exp_wr.delete();
        exp_wr.push_back({8'h00, 8'h55, 8'h00});
        exp_wr.push_back({8'h01, 8'h00, 8'haa});
    endfunction

    // Monitor: bus transactions, sample mixing, word handshakes
    always @(negedge clk) begin
        if (nreset) begin
            if (chk_next) begin
                check("health_after_mix", 32'(health_err), 32'(m_err));
                chk_next = 1'b0;
            end
            if (pend_s) begin
                pend_s = 1'b0;
                if (busy) begin
                    check("health_before_mix", 32'(health_err), 32'(m_err));
                    model_sample(pend_val);
                    chk_next = 1'b1;
                end
            end
            if (!busy) m_half_v = 1'b0;
            if (ent_cs && ent_we) begin
                if (exp_wr.size() == 0) fail_now("unexpected_write", {8'h00, ent_addr, ent_dwrite});
                else check("cfg_write", {8'h00, ent_addr, ent_dwrite}, {8'h00, exp_wr.pop_front()});
            end
            if (ent_cs && !ent_we && ent_addr == 8'h11) begin
                check("cfg_before_read", 32'(exp_wr.size()), 32'd0);
                obs_p  = ent_dread;
                core_n = nxt_n;
            end
            if (ent_cs && !ent_we && ent_addr == 8'h12) begin
                pend_val = obs_p ^ ent_dread;
                pend_s   = 1'b1;
                next_pair();
                core_p   = nxt_p;
            end
            if (data_valid) check("no_bus_in_out", 32'(ent_cs), 32'd0);
            if (data_valid && prev_valid) check("data_stable", data, prev_data);
            if (data_valid && data_ready) begin
                if (exp_words.size() == 0) fail_now("unexpected_word", data);
                else check("word", data, exp_words.pop_front());
                m_words++;
            end
            prev_valid = data_valid;
            prev_data  = data;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) data_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic wait_addr(input logic [7:0] a);
        bit hit = 1'b0;
        for (int k = 0; k < 300 && !hit; k++) begin
            @(negedge clk);
            hit = ent_cs && !ent_we && (ent_addr == a);
        end
        if (!hit) fail_now("bus_read_timeout", 32'(a));
    endtask

    // called just after a posedge; holds cfg_stb for exactly one edge
    task automatic cfg_pulse(input logic [7:0] r1, input logic [7:0] r2);
        rng1_cfg = r1;
        rng2_cfg = r2;
        cfg_stb  = 1'b1;
        model_cfg(r1, r2);
        @(posedge clk);
        #1;
        cfg_stb  = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        check(name, {3'b000, ent_cs, ent_we, ent_addr, ent_dwrite, data_valid, health_err, busy}, 32'd0);
        check({name, "_data"}, data, 32'd0);
    endtask

    initial begin
        int lat;
        logic [7:0] r;
        nreset = 1'b0; enable = 1'b0; cfg_stb = 1'b0; data_ready = 1'b0;
        rng1_cfg = 8'h00; rng2_cfg = 8'h00;
        pairs.push_back({16'h1234, 16'h00ff});
        pairs.push_back({16'h5555, 16'haaaa});
        next_pair();
        core_p = nxt_p;
        core_n = 16'h0000;
        model_reset();
        repeat (3) @(negedge clk);
        check_all_zero("reset");

        // reset config written, first word, backpressure
        nreset = 1'b1;
        @(posedge clk); #1 enable = 1'b1;
        for (int k = 0; k < 200 && !data_valid; k++) @(negedge clk);
        check("first_word", data, 32'hffff12cb);
        repeat (50) @(negedge clk);
        check("held_valid", 32'(data_valid), 32'd1);
        @(posedge clk); #1 data_ready = 1'b1;
        @(posedge clk); #1 data_ready = 1'b0;
        @(negedge clk);
        check("wait_after_accept", {29'd0, data_valid, ent_cs, busy}, 32'b001);

        // enable dropped during RD_N
        wait_addr(8'h11);
        @(posedge clk); #1 enable = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_after_drop", {30'd0, busy, data_valid}, 32'd0);
        repeat (2) @(negedge clk);

        // latency from enable with no pending config
        @(posedge clk); #1 enable = 1'b1; data_ready = 1'b1;
        lat = 0;
        for (int k = 1; k <= 100 && lat == 0; k++) begin
            @(posedge clk); #1;
            if (data_valid) lat = k;
        end
        check("latency", 32'(lat), 32'(2 * (SAMPLE_DIV + 3) + 1));

        // random traffic with reconfiguration in WAIT
        rnd_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_addr(8'h12);
            repeat (3) @(posedge clk);
            #1;
            r = 8'($urandom);
            if (i == 0) cfg_pulse(8'h3c, 8'hc3);
            else        cfg_pulse(r, ~r);
            repeat ($urandom_range(1, 4)) wait_addr(8'h12);
        end

        // repetition test trip and clear
        rnd_ready = 1'b0;
        wait_addr(8'h12);
        repeat (3) @(posedge clk);
        #1 data_ready = 1'b1;
        const_mode = 1'b1;
        cfg_pulse(8'h55, 8'haa);
        for (int i = 0; i < 12 && !m_err; i++) begin
            wait_addr(8'h12);
            repeat (2) @(negedge clk);
        end
        check("health_set", 32'(health_err), 32'd1);
        @(posedge clk); #1;
        cfg_pulse(8'h21, 8'hde);
        @(negedge clk);
        check("health_clear", 32'(health_err), 32'd0);
        const_mode = 1'b0;

        // asynchronous reset in WAIT
        wait_addr(8'h12);
        repeat (5) @(negedge clk);
        #2 nreset = 1'b0;
        #1 check_all_zero("reset_async");
        model_reset();
        @(negedge clk);
        @(posedge clk); #2 nreset = 1'b1;

        // fresh counters: a few words, then a trip
        for (int i = 0; i < 20 && m_words < 3; i++) wait_addr(8'h12);
        const_mode = 1'b1;
        for (int i = 0; i < 20 && m_trips < 1; i++) wait_addr(8'h12);
        wait_addr(8'h11);
        @(posedge clk); #1 enable = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_final", 32'(busy), 32'd0);
        check("words_drained", 32'(exp_words.size()), 32'd0);
        check("writes_drained", 32'(exp_wr.size()), 32'd0);
`ifdef ENTROPY_CTRL_STATS_EN
        check("words_cnt", 32'(words_cnt), 32'(m_words));
        check("fail_cnt", 32'(fail_cnt), 32'(m_trips));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

endmodule
